step_ramp_generator: RTL and testbench

//  Trapezoidal velocity-profile generator directly upstream of motor_driver.

---
 rtl/step_ramp_generator.sv | 142 ++++++++++++++
 tb/tb_step_ramp_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/step_ramp_generator.sv
// Trapezoidal step-period profile generator feeding motor_driver.
// The divider max value ramps START_PERIOD -> MIN_PERIOD -> START_PERIOD, and each step_in rising edge advances the profile.
module step_ramp_generator #(
    parameter int SPEED_W      = 64,
    parameter int CNT_W        = 32,
    parameter int START_PERIOD = 100,
    parameter int MIN_PERIOD   = 40,
    parameter int ACCEL_DELTA  = 20
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [CNT_W-1:0]   cmd_steps_in,
    input  logic               abort_in,
    input  logic               step_in,
    output logic [SPEED_W-1:0] speed_out,
    output logic               step_enable_out,
    output logic               busy_out,
    output logic               done_out
);

    // state  | meaning
    // IDLE   | waiting for a move command, step generation off
    // ACCEL  | period shrinking by ACCEL_DELTA per step
    // CRUISE | period held at MIN_PERIOD
    // DECEL  | period growing back toward START_PERIOD
    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

    localparam logic [SPEED_W:0]   START_X = (SPEED_W+1)'(START_PERIOD);
    localparam logic [SPEED_W:0]   MIN_X   = (SPEED_W+1)'(MIN_PERIOD);
    localparam logic [SPEED_W:0]   DELTA_X = (SPEED_W+1)'(ACCEL_DELTA);
    localparam logic [SPEED_W-1:0] START_S = SPEED_W'(START_PERIOD);
    localparam logic [SPEED_W-1:0] MIN_S   = SPEED_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   ZERO_C  = '0;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic [CNT_W-1:0]   acc_cnt, acc_cnt_nxt;
    logic [SPEED_W-1:0] speed_nxt;
    logic               step_enable_nxt;
    logic               done_nxt;
    logic               step_prev;
    logic               edge_det;
    logic [CNT_W-1:0]   rem_dec;
    logic [SPEED_W:0]   speed_up, speed_dn;
    logic [SPEED_W-1:0] up_clamped, dn_clamped;
    logic [CNT_W:0]     abort_limit;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state           <= IDLE;
            remaining       <= '0;
            acc_cnt         <= '0;
            speed_out       <= START_S;
            step_enable_out <= 1'b0;
            done_out        <= 1'b0;
            step_prev       <= 1'b0;
        end else begin
            state           <= state_nxt;
            remaining       <= remaining_nxt;
            acc_cnt         <= acc_cnt_nxt;
            speed_out       <= speed_nxt;
            step_enable_out <= step_enable_nxt;
            done_out        <= done_nxt;
            step_prev       <= step_in;
        end
    end

    always_comb begin
        edge_det   = step_in & ~step_prev;
        rem_dec    = remaining - ONE_C;
        speed_up   = {1'b0, speed_out} + DELTA_X;
        speed_dn   = {1'b0, speed_out} - DELTA_X;
        up_clamped = (speed_up > START_X) ? START_S : speed_up[SPEED_W-1:0];
        // A borrow out of the top bit means the subtraction wrapped below zero.
        dn_clamped = (speed_dn[SPEED_W] || (speed_dn < MIN_X)) ? MIN_S : speed_dn[SPEED_W-1:0];
    end

    always_comb begin
        state_nxt       = state;
        remaining_nxt   = remaining;
        acc_cnt_nxt     = acc_cnt;
        speed_nxt       = speed_out;
        step_enable_nxt = step_enable_out;
        done_nxt        = 1'b0;
        abort_limit     = '0;

        case (state)
            IDLE: begin
                if (cmd_valid_in) begin
                    if (cmd_steps_in != ZERO_C) begin
                        remaining_nxt   = cmd_steps_in;
                        acc_cnt_nxt     = '0;
                        speed_nxt       = START_S;
                        step_enable_nxt = 1'b1;
                        state_nxt       = ACCEL;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (edge_det) begin
                    remaining_nxt = rem_dec;
                    if (rem_dec == ZERO_C) begin
                        step_enable_nxt = 1'b0;
                        speed_nxt       = START_S;
                        acc_cnt_nxt     = '0;
                        done_nxt        = 1'b1;
                        state_nxt       = IDLE;
                    end else if (state == DECEL) begin
                        speed_nxt   = up_clamped;
                        acc_cnt_nxt = (acc_cnt == ZERO_C) ? ZERO_C : acc_cnt - ONE_C;
                    end else if (rem_dec <= acc_cnt) begin
                        // Steps left equal the steps spent accelerating: start ramp-down.
                        speed_nxt   = up_clamped;
                        acc_cnt_nxt = acc_cnt - ONE_C;
                        state_nxt   = DECEL;
                    end else if (state == ACCEL) begin
                        speed_nxt   = dn_clamped;
                        acc_cnt_nxt = acc_cnt + ONE_C;
                        if (dn_clamped == MIN_S) state_nxt = CRUISE;
                    end
                end

                // Abort acts on the post-edge result so a coincident edge is not lost.
                if (abort_in && (state_nxt == ACCEL || state_nxt == CRUISE)) begin
                    state_nxt   = DECEL;
                    abort_limit = {1'b0, acc_cnt_nxt} + {ZERO_C, 1'b1};
                    if ({1'b0, remaining_nxt} > abort_limit)
                        remaining_nxt = abort_limit[CNT_W-1:0];
                end
            end
        endcase
    end

    assign cmd_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_step_ramp_generator.sv
// Directed bench for step_ramp_generator: the bench plays motor_driver by pulsing step_in by hand.
// Every expected speed value below is hand-derived from the ramp rules.
module tb_step_ramp_generator;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [31:0] cmd_steps_in;
    logic        abort_in;
    logic        step_in;
    logic [63:0] speed_out;
    logic        step_enable_out;
    logic        busy_out;
    logic        done_out;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic        en_seen = 1'b0;
    logic [63:0] min_seen = 64'd100;

    step_ramp_generator dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_steps_in    (cmd_steps_in),
        .abort_in        (abort_in),
        .step_in         (step_in),
        .speed_out       (speed_out),
        .step_enable_out (step_enable_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (done_out) done_cnt++;
        if (step_enable_out) en_seen = 1'b1;
        if (busy_out && speed_out < min_seen) min_seen = speed_out;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; one step pulse, then a check of speed and done right after the edge.
    task automatic do_step(input string tag, input logic [63:0] exp_speed, input logic exp_done);
        step_in = 1'b1;
        @(negedge clk_in);
        chk({tag, "_speed"}, speed_out, exp_speed);
        chk({tag, "_done"}, {63'd0, done_out}, {63'd0, exp_done});
        step_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic start_move(input logic [31:0] steps);
        cmd_valid_in = 1'b1;
        cmd_steps_in = steps;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
    endtask

    int exp10 [10] = '{80, 60, 40, 40, 40, 40, 60, 80, 100, 100};
    int exp5  [9]  = '{80, 60, 40, 40, 40, 60, 80, 100, 100};

    initial begin
        reset_n_in   = 1'b0;
        cmd_valid_in = 1'b0;
        cmd_steps_in = '0;
        abort_in     = 1'b0;
        step_in      = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_speed", speed_out, 64'd100);
        chk("rst_en", {63'd0, step_enable_out}, 64'd0);
        chk("rst_busy", {63'd0, busy_out}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready_out}, 64'd1);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        // 10-step trapezoid
        #1 done_cnt = 0;
        @(negedge clk_in);
        start_move(32'd10);
        chk("t2_busy", {63'd0, busy_out}, 64'd1);
        chk("t2_en", {63'd0, step_enable_out}, 64'd1);
        chk("t2_ready", {63'd0, cmd_ready_out}, 64'd0);
        for (int i = 0; i < 10; i++) do_step($sformatf("t2_e%0d", i + 1), 64'(exp10[i]), i == 9);
        chk("t2_en_end", {63'd0, step_enable_out}, 64'd0);
        chk("t2_busy_end", {63'd0, busy_out}, 64'd0);
        @(negedge clk_in);
        #1 chk("t2_done_cnt", 64'(done_cnt), 64'd1);

        // 4-step triangle never reaches cruise
        done_cnt = 0;
        min_seen = 64'd100;
        @(negedge clk_in);
        start_move(32'd4);
        do_step("t3_e1", 64'd80, 1'b0);
        do_step("t3_e2", 64'd60, 1'b0);
        do_step("t3_e3", 64'd80, 1'b0);
        do_step("t3_e4", 64'd100, 1'b1);
        #1 chk("t3_min", min_seen, 64'd60);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);

        // zero-step command
        done_cnt = 0;
        en_seen  = 1'b0;
        @(negedge clk_in);
        start_move(32'd0);
        chk("t4_done", {63'd0, done_out}, 64'd1);
        chk("t4_busy", {63'd0, busy_out}, 64'd0);
        @(negedge clk_in);
        chk("t4_done_off", {63'd0, done_out}, 64'd0);
        repeat (2) @(negedge clk_in);
        #1 chk("t4_en_seen", {63'd0, en_seen}, 64'd0);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);

        // abort during cruise after edge 5
        @(negedge clk_in);
        start_move(32'd100);
        for (int i = 0; i < 5; i++) do_step($sformatf("t5_e%0d", i + 1), 64'(exp5[i]), 1'b0);
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("t5_abort_busy", {63'd0, busy_out}, 64'd1);
        chk("t5_abort_speed", speed_out, 64'd40);
        for (int i = 5; i < 9; i++) do_step($sformatf("t5_e%0d", i + 1), 64'(exp5[i]), i == 8);
        chk("t5_busy_end", {63'd0, busy_out}, 64'd0);

        // abort while idle is ignored
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        chk("idle_abort_busy", {63'd0, busy_out}, 64'd0);

        // command held high while busy
        done_cnt = 0;
        @(negedge clk_in);
        cmd_valid_in = 1'b1;
        cmd_steps_in = 32'd2;
        @(negedge clk_in);
        do_step("t6_e1", 64'd80, 1'b0);
        chk("t6_busy_mid", {63'd0, busy_out}, 64'd1);
        step_in = 1'b1;
        @(negedge clk_in);
        chk("t6_done", {63'd0, done_out}, 64'd1);
        chk("t6_idle", {63'd0, busy_out}, 64'd0);
        step_in = 1'b0;
        @(negedge clk_in);
        cmd_valid_in = 1'b0;
        chk("t6_restart_busy", {63'd0, busy_out}, 64'd1);
        chk("t6_restart_speed", speed_out, 64'd100);
        chk("t6_restart_en", {63'd0, step_enable_out}, 64'd1);
        do_step("t6_m2_e1", 64'd80, 1'b0);

        // reset in the middle of cruise
        do_step("t1_pre", 64'd100, 1'b1);
        @(negedge clk_in);
        start_move(32'd10);
        for (int i = 0; i < 4; i++) do_step($sformatf("t1_e%0d", i + 1), 64'(exp10[i]), 1'b0);
        reset_n_in = 1'b0;
        @(negedge clk_in);
        chk("t1_en", {63'd0, step_enable_out}, 64'd0);
        chk("t1_speed", speed_out, 64'd100);
        chk("t1_done", {63'd0, done_out}, 64'd0);
        chk("t1_ready", {63'd0, cmd_ready_out}, 64'd1);
        chk("t1_busy", {63'd0, busy_out}, 64'd0);
        reset_n_in = 1'b1;
        @(negedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
